// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared types and opcode constants for the instruction-decode
//               front end (id_decode and id_jump_unit).
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    // One ROM word / one PC value
    typedef logic [15:0] word_t;

    // Boot sequencer states: BOOT loads the PC, FILL waits for ROM data,
    // RUN consumes live ROM words
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Jump opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_JMP = 4'hF;
    localparam logic [3:0] OP_JR  = 4'hE;

endpackage
`default_nettype wire

// File: rtl/id_jump_unit.sv
`default_nettype none
// ============================================================================
// Module      : id_jump_unit
// Description : Combinational jump decoder. Flags unconditional jumps in the
//               ROM word and computes their target from the word's address.
//               Macro ID_DECODE_REL_JUMP_EN enables the PC-relative JR form
//               (opcode 4'hE); without it 4'hE is an ordinary instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module id_jump_unit
    import id_pkg::*;
(
    input  word_t instrucao,
    input  word_t pc_d,
    output logic  is_jump,
    output word_t target
);

    logic [3:0] w_opcode;
    assign w_opcode = instrucao[15:12];

`ifdef ID_DECODE_REL_JUMP_EN
    // Relative target wraps modulo 2^16
    word_t w_rel_target;
    assign w_rel_target = pc_d + {{4{instrucao[11]}}, instrucao[11:0]};
`else
    // Only the page bits of the address feed the absolute jump
    logic w_unused_pc_low;
    assign w_unused_pc_low = ^pc_d[11:0];
`endif

    // Classify the word and select the matching jump target
    always_comb begin
        is_jump = 1'b0;
        target  = '0;
        if (w_opcode == OP_JMP) begin
            is_jump = 1'b1;
            target  = {pc_d[15:12], instrucao[11:0]};
        end
`ifdef ID_DECODE_REL_JUMP_EN
        else if (w_opcode == OP_JR) begin
            is_jump = 1'b1;
            target  = w_rel_target;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/id_decode.sv
`default_nettype none
// ============================================================================
// Module      : id_decode
// Description : Decode front end after fetch. Holds the IF/ID register with a
//               valid/ready handshake, sequences boot (the PC has no reset),
//               decodes unconditional jumps and steers the PC and ROM enables.
//               Macro ID_DECODE_REL_JUMP_EN enables the relative JR jump.
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode
    import id_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
)
(
    input  logic       clock,
    input  logic       reset_n,
    input  word_t      instrucao,
    input  word_t      pc_out,
    output logic       controle_PC,
    output logic       habJump,
    output word_t      jumpPC,
    output logic       Rom_sink_ren,
    output logic       Rom_sink_cen,
    input  logic       id_ready,
    output logic       id_valid,
    output word_t      id_instr,
    output word_t      id_pc,
    output logic [3:0] id_opcode,
    output logic [3:0] id_rd,
    output logic [3:0] id_rs,
    output logic [3:0] id_rt,
    output word_t      id_imm
);

    state_t r_state;
    logic   r_id_valid;
    word_t  r_id_instr;
    word_t  r_id_pc;
    word_t  r_pc_d;

    logic   w_load_en;
    logic   w_is_jump;
    word_t  w_target;
    logic   w_hab;
    word_t  w_jpc;
    logic   w_adv;

    // The IF/ID register can take a new word when empty or being drained
    assign w_load_en = !r_id_valid || id_ready;

    id_jump_unit u_jump (
        .instrucao (instrucao),
        .pc_d      (r_pc_d),
        .is_jump   (w_is_jump),
        .target    (w_target)
    );

    // PC steering and ROM enable from the current state and handshake
    always_comb begin
        w_hab = 1'b0;
        w_jpc = '0;
        w_adv = 1'b0;
        case (r_state)
            BOOT: begin
                w_hab = 1'b1;
                w_jpc = RESET_VECTOR;
            end
            FILL: begin
                w_adv = w_load_en;
            end
            RUN: begin
                w_adv = w_load_en;
                if (w_load_en && w_is_jump) begin
                    w_hab = 1'b1;
                    w_jpc = w_target;
                end
            end
            default: begin
                w_adv = 1'b0;
            end
        endcase
    end

    // Gating with reset_n makes every output drop to its reset value at once
    assign habJump      = reset_n & w_hab;
    assign jumpPC       = reset_n ? w_jpc : '0;
    assign controle_PC  = reset_n & w_adv;
    assign Rom_sink_ren = reset_n & w_adv;
    assign Rom_sink_cen = reset_n;

    // Boot sequencing, fetch-address tracking and IF/ID register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= BOOT;
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_id_pc    <= '0;
            r_pc_d     <= '0;
        end else begin
            // pc_d follows the address whose data the ROM returns next cycle
            if (w_adv) begin
                r_pc_d <= pc_out;
            end
            case (r_state)
                BOOT: begin
                    r_state <= FILL;
                end
                FILL: begin
                    // ROM output is stale here: inject a bubble
                    if (w_load_en) begin
                        r_state    <= RUN;
                        r_id_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_load_en) begin
                        r_id_instr <= instrucao;
                        r_id_pc    <= r_pc_d;
                        r_id_valid <= 1'b1;
                        // Squash the word fetched behind a taken jump
                        if (w_is_jump) begin
                            r_state <= FILL;
                        end
                    end
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_opcode = r_id_instr[15:12];
    assign id_rd     = r_id_instr[11:8];
    assign id_rs     = r_id_instr[7:4];
    assign id_rt     = r_id_instr[3:0];
    assign id_imm    = {{8{r_id_instr[7]}}, r_id_instr[7:0]};

endmodule
`default_nettype wire

// File: tb/tb_id_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_decode
// Description : Self-checking bench for id_decode with a PC/ROM fetch model,
//               a program-order reference model, jump vector table, directed
//               stall/reset sequences and randomized traffic.
//               Honours ID_DECODE_REL_JUMP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_decode;

    localparam logic [15:0] RV = 16'h0000;
`ifdef ID_DECODE_REL_JUMP_EN
    localparam logic REL = 1'b1;
`else
    localparam logic REL = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic [15:0] rom_q;
    logic [15:0] pc_q;
    logic        controle_PC, habJump, Rom_sink_ren, Rom_sink_cen;
    logic [15:0] jumpPC;
    logic        id_ready, id_valid;
    logic [15:0] id_instr, id_pc, id_imm;
    logic [3:0]  id_opcode, id_rd, id_rs, id_rt;

    logic [15:0] rom [0:65535];

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    id_decode #(.RESET_VECTOR(RV)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instrucao    (rom_q),
        .pc_out       (pc_q),
        .controle_PC  (controle_PC),
        .habJump      (habJump),
        .jumpPC       (jumpPC),
        .Rom_sink_ren (Rom_sink_ren),
        .Rom_sink_cen (Rom_sink_cen),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_opcode    (id_opcode),
        .id_rd        (id_rd),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_imm       (id_imm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fetch stage: PC without reset, synchronous ROM
    always @(posedge clock) begin
        if (habJump)          pc_q <= jumpPC;
        else if (controle_PC) pc_q <= pc_q + 16'd1;
        if (Rom_sink_ren)     rom_q <= rom[pc_q];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order: jumps go to their target, everything else to addr+1
    function automatic logic [15:0] next_addr(input logic [15:0] a, input logic [15:0] w);
        logic [15:0] off;
        off = {{4{w[11]}}, w[11:0]};
        if (w[15:12] == 4'hF) return {a[15:12], w[11:0]};
        if (REL && w[15:12] == 4'hE) return a + off;
        return a + 16'd1;
    endfunction

    // Reference stream: every accepted word must be the next in program order
    logic [15:0] m_addr;
    logic [15:0] m_word;
    always @(negedge clock) begin
        if (!reset_n) begin
            m_addr = RV;
        end else if (id_valid && id_ready) begin
            m_word = rom[m_addr];
            chk("stream_id_pc",  id_pc,     m_addr);
            chk("stream_instr",  id_instr,  m_word);
            chk("stream_opcode", id_opcode, m_word[15:12]);
            chk("stream_rd",     id_rd,     m_word[11:8]);
            chk("stream_rs",     id_rs,     m_word[7:4]);
            chk("stream_rt",     id_rt,     m_word[3:0]);
            chk("stream_imm",    id_imm,    {{8{m_word[7]}}, m_word[7:0]});
            m_addr = next_addr(m_addr, m_word);
            n_acc++;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_id_valid"}, id_valid, 0);
        chk({tag, "_habJump"}, habJump, 0);
        chk({tag, "_jumpPC"}, jumpPC, 0);
        chk({tag, "_controle_PC"}, controle_PC, 0);
        chk({tag, "_ren"}, Rom_sink_ren, 0);
        chk({tag, "_cen"}, Rom_sink_cen, 0);
        chk({tag, "_id_instr"}, id_instr, 0);
        chk({tag, "_id_pc"}, id_pc, 0);
    endtask

    // Assert reset between edges; outputs must clear without a clock edge
    task automatic hold_reset();
        @(posedge clock);
        #1 reset_n = 1'b0;
        id_ready = 1'b1;
        #1 check_reset_values("rst");
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // c0..c3 after reset release; returns at the c3 sample point
    task automatic check_boot();
        @(negedge clock);
        chk("c0_habJump", habJump, 1);
        chk("c0_jumpPC", jumpPC, RV);
        chk("c0_ren", Rom_sink_ren, 0);
        chk("c0_cen", Rom_sink_cen, 1);
        chk("c0_id_valid", id_valid, 0);
        @(negedge clock);
        chk("c1_pc_out", pc_q, RV);
        chk("c1_habJump", habJump, 0);
        chk("c1_ren", Rom_sink_ren, 1);
        chk("c1_id_valid", id_valid, 0);
        @(negedge clock);
        chk("c2_instrucao", rom_q, rom[RV]);
        chk("c2_id_valid", id_valid, 0);
        @(negedge clock);
        chk("c3_id_valid", id_valid, 1);
        chk("c3_id_pc", id_pc, RV);
    endtask

    task automatic clear_rom_low();
        for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
        rom[16'hFFFF] = 16'h0000;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
        logic        exp_hab;
        logic [15:0] exp_tgt;
    } vec_t;

    vec_t        vt [6];
    logic [15:0] stall_pc;
    int          n0;
    int          r;
    logic [15:0] t16, off16;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h0003, 16'hF120, 1'b1, 16'h0120};
        vt[1] = '{16'h0005, 16'h1234, 1'b0, 16'h0000};
        vt[2] = '{16'h0010, 16'hEFFE, REL,  16'h000E};
        vt[3] = '{16'h0000, 16'hEFFF, REL,  16'hFFFF};
        vt[4] = '{16'h0002, 16'hF0FF, 1'b1, 16'h00FF};
        vt[5] = '{16'h0004, 16'hDFFF, 1'b0, 16'h0000};

        for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
        pc_q     = 16'hBEEF;
        rom_q    = 16'h0000;
        id_ready = 1'b1;
        reset_n  = 1'b0;

        // Boot with an all-NOP ROM
        hold_reset();
        release_reset();
        check_boot();
        @(negedge clock);
        chk("boot_id_pc_1", id_pc, 16'h0001);
        @(negedge clock);
        chk("boot_id_pc_2", id_pc, 16'h0002);

        // Jump vector table
        for (int k = 0; k < 6; k++) begin
            hold_reset();
            clear_rom_low();
            rom[vt[k].addr] = vt[k].word;
            release_reset();
            repeat (int'(vt[k].addr) + 2) @(posedge clock);
            @(negedge clock);
            chk("tbl_habJump", habJump, vt[k].exp_hab);
            if (vt[k].exp_hab) chk("tbl_jumpPC", jumpPC, vt[k].exp_tgt);
            @(negedge clock);
            chk("tbl_id_pc", id_pc, vt[k].addr);
            chk("tbl_id_instr", id_instr, vt[k].word);
            chk("tbl_hab_one_cycle", habJump, 0);
            @(negedge clock);
            if (vt[k].exp_hab) chk("tbl_bubble", id_valid, 0);
            else               chk("tbl_next_pc", id_pc, vt[k].addr + 16'd1);
            @(negedge clock);
            chk("tbl_valid_after", id_valid, 1);
            if (vt[k].exp_hab) chk("tbl_target_pc", id_pc, vt[k].exp_tgt);
        end

        // Three-cycle stall with a live word
        hold_reset();
        clear_rom_low();
        release_reset();
        check_boot();
        @(posedge clock);
        #1 id_ready = 1'b0;
        stall_pc = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_controle_PC", controle_PC, 0);
            chk("stall_ren", Rom_sink_ren, 0);
            chk("stall_id_valid", id_valid, 1);
            chk("stall_id_pc", id_pc, stall_pc);
            chk("stall_id_instr", id_instr, 16'h0000);
        end
        @(posedge clock);
        #1 id_ready = 1'b1;
        @(negedge clock);
        chk("unstall_id_pc", id_pc, stall_pc);
        chk("unstall_controle_PC", controle_PC, 1);
        @(negedge clock);
        chk("unstall_next_pc", id_pc, stall_pc + 16'd1);

        // Stall while a jump word sits at the ROM output
        hold_reset();
        clear_rom_low();
        rom[7] = 16'hF040;
        release_reset();
        check_boot();
        repeat (6) @(posedge clock);
        #1 id_ready = 1'b0;
        chk("js_rom_out", rom_q, 16'hF040);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("js_stall_habJump", habJump, 0);
            chk("js_stall_controle_PC", controle_PC, 0);
        end
        @(posedge clock);
        #1 id_ready = 1'b1;
        @(negedge clock);
        chk("js_release_habJump", habJump, 1);
        chk("js_release_jumpPC", jumpPC, 16'h0040);
        @(negedge clock);
        chk("js_after_habJump", habJump, 0);

        // Randomized program and backpressure with a mid-stream reset
        hold_reset();
        for (int a = 0; a < 256; a++) begin
            r   = $urandom_range(0, 15);
            t16 = 16'($urandom_range(0, 255));
            if (r == 0) begin
                rom[a] = {4'hF, 4'h0, t16[7:0]};
            end else if (r == 1) begin
                off16  = t16 - 16'(a);
                rom[a] = {4'hE, off16[11:0]};
            end else begin
                rom[a] = {4'($urandom_range(0, 13)), 12'($urandom)};
            end
        end
        rom[255] = 16'hF000;
        release_reset();
        check_boot();
        n0 = n_acc;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1 id_ready = ($urandom_range(0, 9) < 7);
            if (c == 1500) begin
                #1 reset_n = 1'b0;
                #1;
                chk("async_id_valid", id_valid, 0);
                chk("async_habJump", habJump, 0);
                chk("async_ren", Rom_sink_ren, 0);
                chk("async_cen", Rom_sink_cen, 0);
                id_ready = 1'b1;
                @(posedge clock);
                #1 reset_n = 1'b1;
                check_boot();
            end
        end
        chk("rand_progress", (n_acc - n0) > 1000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_decode.md
# id_decode

Instruction-decode front end that sits directly after the fetch stage. It consumes the synchronous-ROM word and the fetch PC, and holds them in an IF/ID pipeline register with a valid/ready handshake toward execute. It decodes unconditional jumps and drives the PC steering signals (`controle_PC`, `habJump`, `jumpPC`) and the ROM enables back into fetch. It also sequences boot, since the PC itself has no reset.

## Interface
- `RESET_VECTOR`, default 16'h0000: address loaded into the PC in the BOOT cycle.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instrucao`  in  16  ROM output; valid one cycle after the address was presented with `Rom_sink_ren`=1.
- `pc_out`  in  16  current PC, i.e. the address presented to the ROM this cycle.
- `controle_PC`  out  1  1 = PC increments at the edge; 0 = PC holds.
- `habJump`  out  1  1 = PC loads `jumpPC` at the edge; has priority over `controle_PC`.
- `jumpPC`  out  16  jump target.
- `Rom_sink_ren`  out  1  ROM read enable. When 0, the ROM output register holds its value.
- `Rom_sink_cen`  out  1  ROM chip enable; 1 whenever out of reset.
- `id_ready`  in  1  execute accepts the word.
- `id_valid`  out  1  IF/ID register holds a live word.
- `id_instr`  out  16  registered instruction.
- `id_pc`  out  16  address of `id_instr`.
- `id_opcode`  out  4  `id_instr[15:12]`.
- `id_rd`, `id_rs`, `id_rt`  out  4 each  `[11:8]`, `[7:4]`, `[3:0]`.
- `id_imm`  out  16  `id_instr[7:0]` sign-extended.

## Operation
- States: BOOT, FILL, RUN.
  - BOOT: reset state; lasts one cycle.
  - FILL: a ROM read is in flight and its data is not usable yet.
  - RUN: `instrucao` is valid.
- Reset values: `id_valid`=0, `habJump`=0, `jumpPC`=0, `controle_PC`=0, `Rom_sink_ren`=0, `Rom_sink_cen`=0, `id_instr`=0, `id_pc`=0, `pc_d`=0, state=BOOT.
- `load_en` = !`id_valid` | `id_ready`.
- BOOT:
  - Outputs: `habJump`=1, `jumpPC`=`RESET_VECTOR`, `Rom_sink_ren`=0, `Rom_sink_cen`=1.
  - Next state: FILL.
- FILL and RUN:
  - `controle_PC` = `Rom_sink_ren` = `load_en`.
  - `pc_d` <= `pc_out` when `Rom_sink_ren`=1.
- FILL: when `load_en`, go to RUN. The IF/ID register is not loaded; a bubble is injected.
- RUN with `load_en`:
  - IF/ID loads `instrucao` and sets `id_pc` <= `pc_d`.
  - `id_valid` <= 1.
- RUN with `id_valid` & !`id_ready`: everything holds; `id_valid` stays 1.
- Jump decode applies to `instrucao` in RUN only, gated by `load_en`.
  - JMP, opcode 4'hF: `jumpPC` = {`pc_d[15:12]`, `instrucao[11:0]`}.
  - JR, opcode 4'hE: see Configuration.
- On a decoded jump:
  - `habJump`=1 for exactly one cycle.
  - The jump word itself is forwarded to IF/ID; downstream treats it as a no-op.
  - Next state: FILL, which squashes the one word fetched after the jump.
- Without `load_en`, a jump word waiting at the ROM output is not decoded; `habJump` stays 0.
- `habJump` is only ever asserted in BOOT or on a decoded jump.
- Reset asserted mid-operation: all outputs return to reset values immediately and asynchronously. The in-flight word is discarded.

## Timing
- Take the BOOT cycle as c0:
  - c1: FILL, `pc_out`=`RESET_VECTOR`.
  - c2: RUN, `instrucao`=ROM[`RESET_VECTOR`].
  - c3: `id_valid`=1.
- Fetch-to-ID latency: 2 cycles from the address cycle to `id_valid`.
- Throughput: 1 word per cycle while `id_ready`=1.
- Jump penalty: exactly 1 bubble on `id_valid`.
- `habJump`, `jumpPC`, `controle_PC` and `Rom_sink_ren` are combinational from state, `instrucao`, `pc_d`, `id_valid` and `id_ready`.

## Configuration
- `ID_DECODE_REL_JUMP_EN` defined:
  - Opcode 4'hE is JR, with `jumpPC` = `pc_d` + sext(`instrucao[11:0]`).
  - Addition is modulo 2^16 (wraps).
- Not defined: 4'hE is an ordinary instruction, `habJump` stays 0 for it, and no adder is synthesized.

## Structure
- Package `id_pkg`:
  - `state_t` enum {BOOT, FILL, RUN}.
  - Opcode constants `OP_JMP`=4'hF, `OP_JR`=4'hE.
  - 16-bit word typedef.
- Sub-module `id_jump_unit`: combinational. Takes `instrucao` and `pc_d`; produces `is_jump` and `target`. It contains the JR adder under the macro.

## Test plan
- Reset release, `RESET_VECTOR`=0, ROM filled with 16'h0000 → c0: `habJump`=1, `jumpPC`=0; `id_valid` rises in c3 with `id_pc`=0000, then 0001, 0002 on consecutive cycles.
- ROM[0003]=16'hF120 → `habJump` high for one cycle with `jumpPC`=16'h0120; `id_pc` sequence is 0003, bubble, 0120; 0004 never appears.
- Macro defined, ROM[0010]=16'hEFFE → `jumpPC`=16'h000E; ROM[0000]=16'hEFFF gives 16'hFFFF (wrap). Macro undefined → `habJump` stays 0 and the word passes as data.
- `id_ready`=0 for 3 cycles while `id_valid`=1:
  - During the stall: `controle_PC`=0, `Rom_sink_ren`=0, ID outputs stable.
  - After release: `id_pc` continues with no skipped or duplicated address.
- Stall while ROM[0007]=16'hF040 sits at the ROM output → `habJump` stays 0 during the stall, then asserts exactly one cycle after `id_ready` rises.
- `reset_n` pulsed low mid-stream → `id_valid`=0 and `habJump`=0 without waiting for a clock edge; after release the c0–c3 boot sequence repeats.
